// File: rtl/regalu_pkg.sv
// Shared types for the register-file/ALU datapath: opcodes, the zero register
// index and the writeback-stage record.
package regalu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    localparam int ZERO_REG = 0;

    // Record widths track the default datapath; widen these for larger builds.
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
        logic                 eq;
        logic                 lt;
    } wb_stage_t;

endpackage

// File: rtl/regalu_pipe_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_WIDTH
// cycles per operation; done is high during the final step with product valid.
module mul_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] step_sum;

    assign step_sum = acc + (mplier[0] ? mcand : '0);
    assign done     = busy && (count == CW'(DATA_WIDTH - 1));
    assign product  = step_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= step_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/regalu_pipe.sv
// Register file + ALU with a registered writeback stage and operand forwarding.
// Define REGALU_MUL_EN to build the iterative multiplier and its issue-stall FSM.
module regalu_pipe
    import regalu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int A0_INDEX      = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic                     reg_write,
    input  logic                     alu_src,
    input  logic [3:0]               alu_ctrl,
    input  logic [DATA_WIDTH-1:0]    imm_op,
    output logic                     wb_valid,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     eq,
    output logic                     lt,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int SHW  = $clog2(DATA_WIDTH);
    localparam int NREG = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZR     = ADDRESS_WIDTH'(ZERO_REG);
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(A0_INDEX);

    function automatic logic [DATA_WIDTH-1:0] alu(input alu_op_e op,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        logic [SHW-1:0]               sh;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return DATA_WIDTH'(sa < sb);
            ALU_SLTU: return DATA_WIDTH'(a < b);
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return sa >>> sh;
            default:  return '0;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0]    regs [NREG];
    wb_stage_t                wb_p1;
    wb_stage_t                mul_wb;
    logic [DATA_WIDTH-1:0]    wbd;
    logic [ADDRESS_WIDTH-1:0] wbrd;
    logic [DATA_WIDTH-1:0]    op1_p0, op2_p0, rs2v_p0, res_p0;
    logic signed [DATA_WIDTH-1:0] op1s_p0, op2s_p0;
    logic                     eq_p0, lt_p0;
    logic                     accept, is_mul, mul_done;

    assign wbd      = DATA_WIDTH'(wb_p1.data);
    assign wbrd     = ADDRESS_WIDTH'(wb_p1.rd);
    assign accept   = in_valid && in_ready;
    assign wb_valid = wb_p1.valid;
    assign wb_data  = wbd;
    assign eq       = wb_p1.eq;
    assign lt       = wb_p1.lt;
    assign a0       = regs[A0_IDX];

    // Stage p0: operand read with forwarding from the writeback register
    always_comb begin
        op1_p0 = (rs1 == ZR) ? '0 : regs[rs1];
        if (wb_p1.valid && wb_p1.we && wbrd == rs1 && rs1 != ZR)
            op1_p0 = wbd;
        rs2v_p0 = (rs2 == ZR) ? '0 : regs[rs2];
        if (wb_p1.valid && wb_p1.we && wbrd == rs2 && rs2 != ZR)
            rs2v_p0 = wbd;
        op2_p0  = alu_src ? imm_op : rs2v_p0;
        op1s_p0 = op1_p0;
        op2s_p0 = op2_p0;
        eq_p0   = (op1_p0 == op2_p0);
        lt_p0   = (op1s_p0 < op2s_p0);
        res_p0  = alu(alu_op_e'(alu_ctrl), op1_p0, op2_p0);
    end

`ifdef REGALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e                state;
    logic                  mul_busy;
    logic [DATA_WIDTH-1:0] mul_prod;
    logic [WB_ADDR_W-1:0]  mul_rd;
    logic                  mul_we, mul_eq, mul_lt;

    assign is_mul = (alu_op_e'(alu_ctrl) == ALU_MUL);

    mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (op1_p0),
        .b       (op2_p0),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            mul_rd   <= '0;
            mul_we   <= 1'b0;
            mul_eq   <= 1'b0;
            mul_lt   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept && is_mul) begin
                    state    <= S_MUL;
                    in_ready <= 1'b0;
                    mul_rd   <= WB_ADDR_W'(rd);
                    mul_we   <= reg_write;
                    mul_eq   <= eq_p0;
                    mul_lt   <= lt_p0;
                end
                S_MUL: if (mul_done || !mul_busy) begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        mul_wb       = '0;
        mul_wb.valid = 1'b1;
        mul_wb.we    = mul_we;
        mul_wb.rd    = mul_rd;
        mul_wb.data  = WB_DATA_W'(mul_prod);
        mul_wb.eq    = mul_eq;
        mul_wb.lt    = mul_lt;
    end
`else
    assign in_ready = 1'b1;
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_wb   = '0;
`endif

    // Stage p1: writeback register; data/eq/lt hold when nothing retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_p1 <= '0;
        end else if (accept && !is_mul) begin
            wb_p1.valid <= 1'b1;
            wb_p1.we    <= reg_write;
            wb_p1.rd    <= WB_ADDR_W'(rd);
            wb_p1.data  <= WB_DATA_W'(res_p0);
            wb_p1.eq    <= eq_p0;
            wb_p1.lt    <= lt_p0;
        end else if (mul_done) begin
            wb_p1 <= mul_wb;
        end else begin
            wb_p1.valid <= 1'b0;
        end
    end

    // Stage p2: register file commit; register 0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_p1.valid && wb_p1.we && wbrd != ZR) begin
            regs[wbrd] <= wbd;
        end
    end

endmodule

// File: doc/regalu_pipe.md
Name: regalu_pipe

Overview:
Parametrised successor to the single-cycle register-file/ALU datapath. It has a registered writeback stage with operand forwarding, a 4-bit ALU opcode covering shifts and compares, and a valid/ready issue handshake. An iterative multiplier is optional and stalls issue while it runs. It sits between the control unit (decode signals, ImmOp) and the branch logic (eq/lt) in the full CPU.

Parameters:
DATA_WIDTH, 32, width of registers, operands and result
ADDRESS_WIDTH, 5, register index width; the file holds 2**ADDRESS_WIDTH registers
A0_INDEX, 10, register index mirrored on the a0 output

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  an instruction is presented
in_ready  output  1  the block accepts an instruction this cycle
rs1  input  ADDRESS_WIDTH  source register 1
rs2  input  ADDRESS_WIDTH  source register 2
rd  input  ADDRESS_WIDTH  destination register
reg_write  input  1  write the result to rd
alu_src  input  1  0 selects rs2 as operand 2; 1 selects imm_op
alu_ctrl  input  4  ALU opcode (alu_op_e)
imm_op  input  DATA_WIDTH  immediate operand
wb_valid  output  1  the writeback register holds a result this cycle
wb_data  output  DATA_WIDTH  registered ALU result
eq  output  1  registered (op1 == op2) for the result in writeback
lt  output  1  registered signed (op1 < op2) for the result in writeback
a0  output  DATA_WIDTH  architectural contents of register A0_INDEX

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: all registers cleared to 0. wb_valid=0, wb_data=0, eq=0, lt=0, a0=0, in_ready=1. FSM goes to IDLE.
- Issue: an instruction is accepted when in_valid && in_ready.
- Operand read: rs1/rs2 are read combinationally from the file.
- Forwarding: if wb_valid && wb_we && wb_rd==rsX && rsX!=0, use wb_data instead of the file value.
- Register 0: reads as 0; writes to it are dropped.
- op2 is selected as alu_src ? imm_op : forwarded rs2.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (feature-gated). All other codes give result 0.
- Shift amount is op2[$clog2(DATA_WIDTH)-1:0]. All arithmetic is modulo 2**DATA_WIDTH.
- Timing: for a single-cycle op accepted at cycle N:
  - Edge N+1 loads wb_data, eq, lt, wb_rd and wb_we, and sets wb_valid=1.
  - Edge N+2 writes the register file; a0 updates then.
- No accepted issue in a cycle: wb_valid=0 next cycle. wb_data, eq and lt hold their values.
- Same-register conflict: a writeback and a new issue reading that register in the same cycle are resolved by forwarding; the reader sees the new value.
- Back-to-back dependent ops need no stall.
- FSM states (MUL path only): IDLE and MUL.
  - in_ready = (state == IDLE).
  - Accepting MUL at cycle N: operands are captured after forwarding, and the FSM enters MUL with count=0.
  - Each MUL cycle performs one shift-add step and increments count.
  - At count == DATA_WIDTH-1, the low DATA_WIDTH product bits load into writeback: wb_valid=1 at edge N+DATA_WIDTH+1. The FSM returns to IDLE and in_ready=1 in that cycle.
  - eq and lt for a MUL reflect its operands.
  - A writeback pending from before the MUL still retires normally during the MUL.
- Reset asserted mid-MUL: the multiply is aborted, with no writeback or register write.
- in_valid while in_ready=0: the instruction is ignored; the upstream holds it.

Optional Feature:
REGALU_MUL_EN
- Defined: opcode 10 runs the iterative multiply described above; in_ready deasserts for DATA_WIDTH cycles.
- Undefined: opcode 10 behaves as an unknown opcode (single-cycle, result 0). The FSM and multiplier are not built, and in_ready is tied to 1.

Decomposition:
- Package regalu_pkg: alu_op_e enum (4-bit, codes above), ZERO_REG constant, and the wb_stage_t struct {valid, we, rd, data, eq, lt}.
- One sub-module, mul_iter (iterative shift-add, start/busy/done interface), instantiated only under REGALU_MUL_EN.
- The register file stays inline.

Test Plan:
- Reset, then ADD imm: rs1=0, imm=5, rd=1 → wb_data=5 at N+1, r1=5 at N+2.
- Forwarding: ADDI r1=7, then SUB r2=r1-r1 on the next cycle → wb_data=0, eq=1; no stall.
- Writes to x0 and shifts: ADDI x0=9, then ADD r3=x0+x0 → 0. SRA r4 with -8 by 1 → 0xFFFFFFFC; SLTU of 1 vs -1 → 1.
- A0 path: ADDI r10=0x1234 → a0=0x1234 two edges after issue; other writes leave a0 unchanged.
- MUL (REGALU_MUL_EN): 6*7 → in_ready=0 for 32 cycles, wb_data=42 at N+33. in_valid held during the stall is ignored. Without the macro, MUL gives result 0 at N+1.
- rst_n pulsed mid-MUL → in_ready=1, wb_valid=0, destination register still 0.
